// File: rtl/vend_req_arbiter.sv
// Round-robin front end for a shared vending core: picks one panel, latches
// its operands, walks the core through select/pay and returns the result
// to that panel with a one-cycle ack.
module vend_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_item,
  input  logic [4*NUM_REQ-1:0] req_noi,
  input  logic [8*NUM_REQ-1:0] req_amt,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 resp_err,
  output logic [7:0]           resp_cost,
  output logic                 busy,
  output logic [2:0]           grant_id,
  output logic                 vm_enable_item,
  output logic                 vm_enable_noi,
  output logic                 vm_enable_amt,
  output logic [3:0]           vm_selected_item,
  output logic [3:0]           vm_num_items,
  output logic [7:0]           vm_entered_amount,
  input  logic                 vm_done,
  input  logic                 vm_error,
  input  logic [7:0]           vm_cost
);

  typedef enum logic [2:0] {IDLE, SEL, CHK, AMT, WAIT, RESP} state_t;

  localparam logic [3:0] TMAX = 4'(TIMEOUT);

  state_t      state_q, state_d;
  logic [2:0]  ptr;
  logic [2:0]  win;
  logic        found;
  logic [3:0]  win_item, win_noi;
  logic [7:0]  win_amt;
  logic        err_q;
  logic [7:0]  cost_q;
  logic [3:0]  tcnt;
  logic        tlast;

  // The counter is about to hit TIMEOUT on this WAIT cycle.
  assign tlast = (tcnt == TMAX - 4'd1);
  assign busy  = (state_q != IDLE);

  // Round-robin pick: nearest requester at or above ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && ((int'(ptr) + k) % NUM_REQ == i)) begin
          found = 1'b1;
          win   = 3'(i);
        end
      end
    end
  end

  // Mux out the winning panel's operand slices.
  always_comb begin
    win_item = '0;
    win_noi  = '0;
    win_amt  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == 3'(i)) begin
        win_item = req_item[4*i +: 4];
        win_noi  = req_noi[4*i +: 4];
        win_amt  = req_amt[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus the core strobes and the response, all decoded from state.
  always_comb begin
    state_d        = state_q;
    vm_enable_item = 1'b0;
    vm_enable_noi  = 1'b0;
    vm_enable_amt  = 1'b0;
    ack            = '0;
    resp_err       = 1'b0;
    resp_cost      = '0;
    case (state_q)
      IDLE: if (found) state_d = SEL;
      SEL: begin
        vm_enable_item = 1'b1;
        vm_enable_noi  = 1'b1;
        state_d        = CHK;
      end
      CHK:  state_d = vm_done ? RESP : AMT;
      AMT: begin
        vm_enable_amt = 1'b1;
        state_d       = WAIT;
      end
      WAIT: if (vm_done || tlast) state_d = RESP;
      RESP: begin
        for (int i = 0; i < NUM_REQ; i++) ack[i] = (grant_id == 3'(i));
        resp_err  = err_q;
        resp_cost = cost_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, operand latch, result capture, timeout counter and rr pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr               <= '0;
      grant_id          <= '0;
      vm_selected_item  <= '0;
      vm_num_items      <= '0;
      vm_entered_amount <= '0;
      err_q             <= 1'b0;
      cost_q            <= '0;
      tcnt              <= '0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          grant_id          <= win;
          vm_selected_item  <= win_item;
          vm_num_items      <= win_noi;
          vm_entered_amount <= win_amt;
          err_q             <= 1'b0;
          cost_q            <= '0;
          tcnt              <= '0;
        end
        CHK: if (vm_done) begin
          err_q  <= 1'b1;
          cost_q <= '0;
        end
        // vm_cost is only valid while enable_amt is high, i.e. now.
        AMT: cost_q <= vm_cost;
        WAIT: begin
          if (vm_done) begin
            err_q <= vm_error;
            if (vm_error) cost_q <= '0;
          end else begin
            if (tcnt != TMAX) tcnt <= tcnt + 4'd1;
            if (tlast) begin
              err_q  <= 1'b1;
              cost_q <= '0;
            end
          end
        end
        RESP: ptr <= (grant_id == 3'(NUM_REQ-1)) ? 3'd0 : grant_id + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_req_arbiter.sv
// Directed bench for vend_req_arbiter with a small behavioural vending core.
module tb_vend_req_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [4*N-1:0] req_item, req_noi;
  logic [8*N-1:0] req_amt;
  logic [N-1:0]   ack;
  logic           resp_err;
  logic [7:0]     resp_cost;
  logic           busy;
  logic [2:0]     grant_id;
  logic           vm_enable_item, vm_enable_noi, vm_enable_amt;
  logic [3:0]     vm_selected_item, vm_num_items;
  logic [7:0]     vm_entered_amount;
  logic           vm_done, vm_error;
  logic [7:0]     vm_cost;

  int checks = 0;
  int errors = 0;
  bit hang   = 1'b0;

  vend_req_arbiter #(.NUM_REQ(N), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .req_item(req_item), .req_noi(req_noi),
    .req_amt(req_amt), .ack(ack), .resp_err(resp_err), .resp_cost(resp_cost),
    .busy(busy), .grant_id(grant_id), .vm_enable_item(vm_enable_item),
    .vm_enable_noi(vm_enable_noi), .vm_enable_amt(vm_enable_amt),
    .vm_selected_item(vm_selected_item), .vm_num_items(vm_num_items),
    .vm_entered_amount(vm_entered_amount), .vm_done(vm_done),
    .vm_error(vm_error), .vm_cost(vm_cost)
  );

  always #5 clk = ~clk;

  // Core stub: price = 10 + 2*item, items 0..9 valid, noi must be nonzero;
  // payment fails when amount is below cost. hang suppresses done after AMT.
  logic [7:0] price;
  assign price   = 8'd10 + {3'b000, vm_selected_item, 1'b0};
  assign vm_cost = vm_enable_amt ? 8'(price * {4'b0000, vm_num_items}) : 8'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vm_done  <= 1'b0;
      vm_error <= 1'b0;
    end else begin
      vm_done  <= 1'b0;
      vm_error <= 1'b0;
      if (vm_enable_item && vm_enable_noi &&
          (vm_selected_item > 4'd9 || vm_num_items == 4'd0)) begin
        vm_done  <= 1'b1;
        vm_error <= 1'b1;
      end else if (vm_enable_amt && !hang) begin
        vm_done  <= 1'b1;
        vm_error <= (vm_entered_amount < vm_cost);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic set_panel(input int p, input logic [3:0] it, input logic [3:0] nn,
                           input logic [7:0] am);
    req_item[4*p +: 4] = it;
    req_noi[4*p +: 4]  = nn;
    req_amt[8*p +: 8]  = am;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for ack, sampling on negedges. Tracks strobe counts,
  // strobe overlap, idle cycles and operand stability against expectation.
  int n_item, n_amt, n_ovl, n_idle, n_hold;
  task automatic wait_ack(input int maxc, input bit drop, input logic [15:0] ops,
                          output int lat, output logic [N-1:0] a,
                          output logic e, output logic [7:0] c);
    n_item = 0; n_amt = 0; n_ovl = 0; n_idle = 0; n_hold = 0;
    lat = 0; a = '0; e = 1'b0; c = '0;
    while (lat < maxc) begin
      @(negedge clk);
      lat++;
      if (drop && lat == 1) req = '0;
      if (vm_enable_item) n_item++;
      if (vm_enable_amt) n_amt++;
      if (vm_enable_amt && (vm_enable_item || vm_enable_noi)) n_ovl++;
      if (!busy) n_idle++;
      else if ({vm_selected_item, vm_num_items, vm_entered_amount} != ops) n_hold++;
      if (ack != '0) begin
        a = ack; e = resp_err; c = resp_cost;
        break;
      end
    end
  endtask

  typedef struct {
    int         p;
    logic [3:0] item, noi;
    logic [7:0] amt;
    bit         hng, drop;
    int         lat;
    bit         err;
    logic [7:0] cost;
    int         amtp;
  } vec_t;

  vec_t tv[7];
  int lat;
  logic [N-1:0] a;
  logic e;
  logic [7:0] c;

  initial begin
    tv[0] = '{0, 4'd3, 4'd2, 8'd32,  1'b0, 1'b0, 5,  1'b0, 8'd32,  1}; // good pay
    tv[1] = '{1, 4'd0, 4'd3, 8'd25,  1'b0, 1'b0, 5,  1'b1, 8'd0,   1}; // short pay
    tv[2] = '{2, 4'd12, 4'd1, 8'd99, 1'b0, 1'b0, 3,  1'b1, 8'd0,   0}; // bad item
    tv[3] = '{3, 4'd2, 4'd3, 8'd50,  1'b0, 1'b0, 5,  1'b0, 8'd42,  1}; // overpay
    tv[4] = '{1, 4'd4, 4'd1, 8'd18,  1'b1, 1'b0, 19, 1'b1, 8'd0,   1}; // timeout
    tv[5] = '{2, 4'd5, 4'd2, 8'd40,  1'b0, 1'b1, 5,  1'b0, 8'd40,  1}; // req drop
    tv[6] = '{0, 4'd9, 4'd9, 8'd255, 1'b0, 1'b0, 5,  1'b0, 8'd252, 1}; // max cost

    req = '0; req_item = '1; req_noi = '1; req_amt = '1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_outs", int'({ack, resp_err, resp_cost, busy, grant_id,
                            vm_enable_item, vm_enable_noi, vm_enable_amt}), 0);
    chk("reset_ops", int'({vm_selected_item, vm_num_items, vm_entered_amount}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    for (int t = 0; t < 7; t++) begin
      req_item = '1; req_noi = '1; req_amt = '1;
      set_panel(tv[t].p, tv[t].item, tv[t].noi, tv[t].amt);
      hang = tv[t].hng;
      req  = N'(1) << tv[t].p;
      wait_ack(40, tv[t].drop, {tv[t].item, tv[t].noi, tv[t].amt}, lat, a, e, c);
      req = '0;
      chk($sformatf("v%0d_lat", t), lat, tv[t].lat);
      chk($sformatf("v%0d_ack", t), int'(a), int'(N'(1) << tv[t].p));
      chk($sformatf("v%0d_gid", t), int'(grant_id), tv[t].p);
      chk($sformatf("v%0d_err", t), int'(e), int'(tv[t].err));
      chk($sformatf("v%0d_cost", t), int'(c), int'(tv[t].cost));
      chk($sformatf("v%0d_amtpulse", t), n_amt, tv[t].amtp);
      chk($sformatf("v%0d_selpulse", t), n_item, 1);
      chk($sformatf("v%0d_overlap", t), n_ovl, 0);
      chk($sformatf("v%0d_hold", t), n_hold, 0);
      @(negedge clk);
      chk($sformatf("v%0d_after", t), int'({busy, ack, resp_err, resp_cost}), 0);
    end
    hang = 1'b0;

    // Fairness: all four panels hold req; expect 0,1,2,3,0 six cycles apart.
    do_reset();
    for (int p = 0; p < N; p++) set_panel(p, 4'd1, 4'd1, 8'd12);
    req = '1;
    for (int n = 0; n < 5; n++) begin
      wait_ack(40, 1'b0, {4'd1, 4'd1, 8'd12}, lat, a, e, c);
      chk($sformatf("rr%0d_ack", n), int'(a), int'(N'(1) << (n % N)));
      chk($sformatf("rr%0d_gap", n), lat, (n == 0) ? 5 : 6);
      chk($sformatf("rr%0d_idle", n), n_idle, (n == 0) ? 0 : 1);
      chk($sformatf("rr%0d_cost", n), int'({e, c}), 12);
    end
    req = '0;
    @(negedge clk);

    // Reset while waiting on a hung core: everything clears, no ack.
    hang = 1'b1;
    req_item = '1; req_noi = '1; req_amt = '1;
    set_panel(1, 4'd5, 4'd1, 8'd20);
    req = 4'b0010;
    for (int k = 0; k < 4; k++) @(negedge clk);
    chk("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("rst_outs", int'({ack, resp_err, resp_cost, busy, grant_id,
                          vm_enable_item, vm_enable_noi, vm_enable_amt}), 0);
    chk("rst_ops", int'({vm_selected_item, vm_num_items, vm_entered_amount}), 0);
    @(negedge clk);
    chk("rst_hold_ack", int'(ack), 0);
    hang = 1'b0;
    rst  = 1'b0;
    req_item = '1; req_noi = '1; req_amt = '1;
    set_panel(2, 4'd1, 4'd1, 8'd12);
    req = 4'b0100;
    wait_ack(40, 1'b0, {4'd1, 4'd1, 8'd12}, lat, a, e, c);
    req = '0;
    chk("post_rst_lat", lat, 5);
    chk("post_rst_ack", int'(a), 4);
    chk("post_rst_resp", int'({e, c}), 12);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vend_req_arbiter.md
Name: vend_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one vending core among NUM_REQ customer panels.
- Latches the winning panel's item, count and amount, then steps the core through its select/pay handshake: item+count strobe, then amount strobe.
- Captures the core's result and returns it to the winning panel with a one-cycle ack.
- Sits between the panel front-ends and the vending core; it is the only driver of the core's enable and operand inputs.

Parameters:
- NUM_REQ, 4, number of requesting panels (2..8).
- TIMEOUT, 15, cycles to wait in WAIT for core done before forcing an error response.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-panel request; held high until that panel's ack.
- req_item  input  4*NUM_REQ  per-panel selected item; panel i uses bits [4i+3:4i].
- req_noi  input  4*NUM_REQ  per-panel number of items.
- req_amt  input  8*NUM_REQ  per-panel entered amount.
- ack  output  NUM_REQ  one-hot, one-cycle pulse to the granted panel when its response is valid.
- resp_err  output  1  response error flag; valid while ack is nonzero.
- resp_cost  output  8  cost computed by the core; valid while ack is nonzero; 0 on any error.
- busy  output  1  high in every state except IDLE.
- grant_id  output  3  index of the panel currently being served.
- vm_enable_item  output  1  core item enable.
- vm_enable_noi  output  1  core count enable.
- vm_enable_amt  output  1  core amount enable.
- vm_selected_item  output  4  latched item for the core.
- vm_num_items  output  4  latched count for the core.
- vm_entered_amount  output  8  latched amount for the core.
- vm_done  input  1  core done: high while the core is in its success or error state.
- vm_error  input  1  core registered error flag.
- vm_cost  input  8  core combinational cost; valid only in the cycle enable_amt is asserted.

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE and the round-robin pointer to 0.
  - All outputs are 0, including the latched operands, ack, resp_*, busy and grant_id.
  - Reset mid-transaction abandons the transaction with no ack. The core is reset by the same rst.
- FSM states: IDLE, SEL, CHK, AMT, WAIT, RESP.
- IDLE:
  - If req is nonzero, grant the first set bit searching upward from the pointer, with wrap-around.
  - Latch that panel's item, count and amount into the vm_* operand registers, set grant_id and go to SEL.
  - With no request, stay in IDLE.
- SEL: vm_enable_item=vm_enable_noi=1 for exactly this cycle -> CHK.
- CHK:
  - If vm_done=1, the core rejected the selection: capture err=1, cost=0 -> RESP.
  - Otherwise -> AMT.
- AMT: vm_enable_amt=1 for exactly this cycle; capture vm_cost into the cost register -> WAIT.
- WAIT:
  - If vm_done=1: capture err=vm_error; if err=1, zero the captured cost -> RESP.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT: err=1, cost=0 -> RESP.
- RESP:
  - ack[grant_id]=1 for one cycle; resp_err and resp_cost are driven from the capture registers.
  - Pointer becomes grant_id+1, wrapping to 0 after NUM_REQ-1 -> IDLE.
  - resp_err and resp_cost are 0 whenever ack is 0.
- Latency from req sampled in IDLE to ack:
  - 5 cycles on the normal path (IDLE, SEL, CHK, AMT, WAIT, RESP).
  - 3 cycles on a selection error (IDLE, SEL, CHK, RESP).
- Operand hold: vm_* operands stay constant from SEL through RESP. Panel inputs are ignored after the latch; a panel dropping req mid-transaction still receives its ack.
- Request after ack: a panel that keeps req high after its ack is treated as a new request. It is served last among the active requesters.
- Enable overlap: the core's enables are never asserted outside SEL and AMT, and never together in one cycle.
- Back-to-back transactions: the core returns to idle during RESP, so the next grant's SEL may follow IDLE immediately.
- Arithmetic: cost is not computed here; it is passed through 8 bits wide. The timeout counter is 4 bits wide and saturates at TIMEOUT.

Test Plan:
- Single request, good payment: req=0001, item 3 (price 16), noi 2, amt 32 -> vm_enable_amt pulses 3 cycles after IDLE, ack=0001 at cycle 5, resp_err=0, resp_cost=32.
- Wrong amount: item 0 (price 10), noi 3, amt 25 -> ack at cycle 5, resp_err=1, resp_cost=0.
- Bad selection: item 12, noi 1 -> vm_done high in CHK, ack at cycle 3, resp_err=1, no vm_enable_amt pulse ever issued.
- Fairness: req=1111 held continuously with all-valid requests -> acks in order 0,1,2,3,0, each 6 cycles apart, and busy stays high except for the single IDLE cycle between them.
- Timeout: core stub never asserts vm_done after AMT -> ack 15 cycles after entering WAIT, resp_err=1, resp_cost=0.
- Reset in WAIT: assert rst while in WAIT -> all outputs 0 immediately, no ack; after release with req=0100, panel 2 is served first with nominal latency.
